// File: rtl/call_push_sequencer_pkg.sv
// Shared encodings for the CALL/RST/INT push sequencer: states, kinds, select indices, vector helpers.
package call_push_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_SP_DEC   = 3'd3,
    ST_WAIT_INT = 3'd4,
    ST_PUSH_HI  = 3'd5,
    ST_PUSH_LO  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    KIND_CALL    = 2'd0,
    KIND_CALL_CC = 2'd1,
    KIND_RST     = 2'd2,
    KIND_INT     = 2'd3
  } kind_t;

  localparam int R16_WZ  = 0;
  localparam int R16_VEC = 1;
  localparam int R16_SP  = 4;
  localparam int R16_PC  = 5;

  localparam int REG8_W   = 4;
  localparam int REG8_Z   = 5;
  localparam int REG8_PCH = 6;
  localparam int REG8_PCL = 7;

  localparam logic [7:0] INT_VEC_BASE = 8'h40;

  function automatic logic [5:0] r16_sel(input int idx);
    logic [5:0] sel;
    sel = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  function automatic logic [7:0] reg8_sel(input int idx);
    logic [7:0] sel;
    sel = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  function automatic logic [7:0] int_vector(input logic [2:0] idx);
    return INT_VEC_BASE + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/call_push_sequencer_int_priority_encoder.sv
// Picks the lowest-numbered pending interrupt line; bit 0 has the highest priority.
module call_push_sequencer_int_priority_encoder #(
  parameter int NUM_INT = 5
) (
  input  logic [NUM_INT-1:0] lines,
  output logic               valid,
  output logic [NUM_INT-1:0] ack,
  output logic [2:0]         idx
);

  always_comb begin
    valid = 1'b0;
    ack   = '0;
    idx   = '0;
    // Scan downwards so the lowest set bit is the one left standing.
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (lines[i]) begin
        valid  = 1'b1;
        ack    = '0;
        ack[i] = 1'b1;
        idx    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/call_push_sequencer.sv
// M-cycle sequencer pushing PC for CALL, CALL cc, RST and interrupt dispatch, then reloading PC.
module call_push_sequencer
  import call_push_sequencer_pkg::*;
#(
  parameter int NUM_INT = 5
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [3:0]         i_Cycle_Step,
  input  logic               i_Start,
  input  logic [1:0]         i_Kind,
  input  logic [3:0]         i_Y,
  input  logic [3:0]         i_Conditions,
  input  logic [2:0]         i_Rst_Vec,
  input  logic [NUM_INT-1:0] i_Int_Lines,
  output logic               o_Busy,
  output logic               o_IR_Fetch,
  output logic [7:0]         o_Read8,
  output logic [7:0]         o_Write8,
  output logic [5:0]         o_Read16,
  output logic [5:0]         o_Write16,
  output logic               o_Bus_In,
  output logic               o_Bus_Out,
  output logic               o_Address_Out,
  output logic [1:0]         o_Increment16,
  output logic [1:0]         o_Decrement16,
  output logic [7:0]         o_Vector,
  output logic               o_DI,
  output logic [NUM_INT-1:0] o_Int_Ack
);

  state_t     state;
  kind_t      kind_q;
  logic [3:0] y_q;
  logic [7:0] vec_q;

  logic               int_valid;
  logic [NUM_INT-1:0] int_ack;
  logic [2:0]         int_idx;

  call_push_sequencer_int_priority_encoder #(.NUM_INT(NUM_INT)) u_prio (
    .lines (i_Int_Lines),
    .valid (int_valid),
    .ack   (int_ack),
    .idx   (int_idx)
  );

  logic step_early, step_t3, step_t4, cond_ok, is_call;
  assign step_early = |i_Cycle_Step[2:0];
  assign step_t3    = i_Cycle_Step[2];
  assign step_t4    = i_Cycle_Step[3];
  assign cond_ok    = |(y_q & i_Conditions);
  assign is_call    = (kind_q == KIND_CALL) || (kind_q == KIND_CALL_CC);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= ST_IDLE;
      kind_q <= KIND_CALL;
      y_q    <= '0;
      vec_q  <= '0;
    end else if (step_t4) begin
      case (state)
        ST_IDLE: if (i_Start) begin
          kind_q <= kind_t'(i_Kind);
          y_q    <= i_Y;
          vec_q  <= (kind_t'(i_Kind) == KIND_RST) ? {2'b00, i_Rst_Vec, 3'b000} : 8'h00;
          case (kind_t'(i_Kind))
            KIND_CALL, KIND_CALL_CC: state <= ST_FETCH_LO;
            KIND_RST:                state <= ST_SP_DEC;
            default:                 state <= ST_WAIT_INT;
          endcase
        end
        ST_FETCH_LO: state <= ST_FETCH_HI;
        ST_FETCH_HI: state <= (kind_q == KIND_CALL_CC && !cond_ok) ? ST_IDLE : ST_SP_DEC;
        ST_SP_DEC:   state <= ST_PUSH_HI;
        ST_WAIT_INT: state <= ST_SP_DEC;
        ST_PUSH_HI: begin
          // Interrupt vector is resolved as late as possible, from the lines live at this edge.
          if (kind_q == KIND_INT) vec_q <= int_valid ? int_vector(int_idx) : 8'h00;
          state <= ST_PUSH_LO;
        end
        ST_PUSH_LO:  state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_Busy        = (state != ST_IDLE);
    o_IR_Fetch    = 1'b0;
    o_Read8       = '0;
    o_Write8      = '0;
    o_Read16      = '0;
    o_Write16     = '0;
    o_Bus_In      = 1'b0;
    o_Bus_Out     = 1'b0;
    o_Address_Out = 1'b0;
    o_Increment16 = '0;
    o_Decrement16 = '0;
    o_Vector      = '0;
    o_DI          = 1'b0;
    o_Int_Ack     = '0;
    case (state)
      ST_FETCH_LO, ST_FETCH_HI: begin
        o_Read16      = r16_sel(R16_PC);
        o_Address_Out = 1'b1;
        if (step_t3) begin
          o_Bus_In = 1'b1;
          o_Write8 = (state == ST_FETCH_LO) ? reg8_sel(REG8_Z) : reg8_sel(REG8_W);
        end
        if (step_t4) begin
          o_Increment16 = 2'b01;
          if (state == ST_FETCH_HI && kind_q == KIND_CALL_CC && !cond_ok) o_IR_Fetch = 1'b1;
        end
      end
      ST_SP_DEC: if (step_t4) o_Decrement16 = 2'b01;
      ST_WAIT_INT: o_DI = 1'b1;
      ST_PUSH_HI: begin
        if (step_early) begin
          o_Read16      = r16_sel(R16_SP);
          o_Address_Out = 1'b1;
          o_Read8       = reg8_sel(REG8_PCH);
          o_Bus_Out     = 1'b1;
        end
        if (step_t4) begin
          o_Decrement16 = 2'b01;
          if (kind_q == KIND_INT) o_Int_Ack = int_ack;
        end
      end
      ST_PUSH_LO: begin
        if (!is_call) o_Vector = vec_q;
        if (step_early) begin
          o_Read16      = r16_sel(R16_SP);
          o_Address_Out = 1'b1;
          o_Read8       = reg8_sel(REG8_PCL);
          o_Bus_Out     = 1'b1;
        end
        if (step_t4) begin
          o_Read16   = is_call ? r16_sel(R16_WZ) : r16_sel(R16_VEC);
          o_Write16  = r16_sel(R16_PC);
          o_IR_Fetch = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_call_push_sequencer.sv
// Directed bench: drives T-steps, emulates PC/SP/WZ/memory from the strobes, checks results per vector.
module tb_call_push_sequencer;
  import call_push_sequencer_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] step;
  logic       start;
  logic [1:0] kind;
  logic [3:0] y, cond;
  logic [2:0] rst_idx;
  logic [4:0] lines;
  logic       busy, irf, bus_in, bus_out, addr_out, di;
  logic [7:0] read8, write8, vector;
  logic [5:0] read16, write16;
  logic [1:0] inc16, dec16;
  logic [4:0] ack;

  call_push_sequencer #(.NUM_INT(5)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Cycle_Step(step), .i_Start(start), .i_Kind(kind),
    .i_Y(y), .i_Conditions(cond), .i_Rst_Vec(rst_idx), .i_Int_Lines(lines),
    .o_Busy(busy), .o_IR_Fetch(irf), .o_Read8(read8), .o_Write8(write8),
    .o_Read16(read16), .o_Write16(write16), .o_Bus_In(bus_in), .o_Bus_Out(bus_out),
    .o_Address_Out(addr_out), .o_Increment16(inc16), .o_Decrement16(dec16),
    .o_Vector(vector), .o_DI(di), .o_Int_Ack(ack)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] pc, sp, wz;
  logic [7:0]  mem [0:65535];

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  y;
    logic [3:0]  cond;
    logic [2:0]  rst_idx;
    logic [4:0]  lines;
    logic        clr;
    logic [15:0] init_pc;
    logic [15:0] exp_pc;
    logic [15:0] exp_sp;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    int          exp_m;
    int          exp_busout;
    logic [4:0]  exp_ack;
    logic        exp_di;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {13'd0, busy, irf, read8, write8, read16, write16, bus_in, bus_out, addr_out,
            inc16, dec16, vector, di, ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1 step = {step[2:0], step[3]};
  endtask

  task automatic align_t4();
    while (step != 4'b1000) tick();
  endtask

  // Datapath stand-in: applies the strobes of the current step to PC/SP/WZ/memory.
  task automatic apply_model();
    logic [15:0] a;
    a = read16[R16_SP] ? sp : pc;
    if (bus_in && addr_out) begin
      if (write8[REG8_Z]) wz[7:0]  = mem[a];
      if (write8[REG8_W]) wz[15:8] = mem[a];
    end
    if (bus_out && addr_out) mem[a] = read8[REG8_PCH] ? pc[15:8] : pc[7:0];
    if (write16[R16_PC]) pc = read16[R16_WZ] ? wz : {8'h00, vector};
    if (inc16[0]) pc = pc + 16'd1;
    if (dec16[0]) sp = sp - 16'd1;
  endtask

  task automatic prep_model(input logic [15:0] init_pc);
    pc = init_pc; sp = 16'hFFFE; wz = 16'h0000;
    mem[16'hFFFD] = 8'hAA; mem[16'hFFFC] = 8'hAA;
    mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
  endtask

  task automatic issue(input logic [1:0] k, input logic [3:0] yy, input logic [2:0] ri);
    align_t4();
    start = 1'b1; kind = k; y = yy; rst_idx = ri;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int m, bo, ir, clash, cyc;
    logic [4:0] ack_seen;
    logic di_seen, done;
    string tag;
    tag = $sformatf("v%0d", n);
    prep_model(v.init_pc);
    cond = v.cond; lines = v.lines;
    m = 0; bo = 0; ir = 0; clash = 0; ack_seen = '0; di_seen = 1'b0; done = 1'b0;
    issue(v.kind, v.y, v.rst_idx);
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else begin
        if (step[3]) m++;
        if (bus_out) bo++;
        if (irf) ir++;
        if ((bus_in && bus_out) || (inc16 != 0 && dec16 != 0)) clash++;
        ack_seen = ack_seen | ack;
        di_seen = di_seen | di;
        apply_model();
        if (v.clr && read8[REG8_PCH]) lines = '0;
        tick();
      end
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_pc"}, pc, v.exp_pc);
    check({tag, "_sp"}, sp, v.exp_sp);
    check({tag, "_mem_hi"}, mem[16'hFFFD], v.exp_hi);
    check({tag, "_mem_lo"}, mem[16'hFFFC], v.exp_lo);
    check({tag, "_mcycles"}, m, v.exp_m);
    check({tag, "_bus_out"}, bo, v.exp_busout);
    check({tag, "_ir_fetch"}, ir, 1);
    check({tag, "_ack"}, ack_seen, v.exp_ack);
    check({tag, "_di"}, di_seen, v.exp_di);
    check({tag, "_clash"}, clash, 0);
    check({tag, "_idle_out"}, all_outputs(), 64'd0);
  endtask

  initial begin
    int cyc, ir;
    logic hit;
    rst = 1'b1; step = 4'b0001; start = 1'b0; kind = '0; y = '0; cond = '0;
    rst_idx = '0; lines = '0;
    prep_model(16'h0100);

    //             kind y     cond   ri    lines     clr  pc0      pc       sp       hi     lo     m busout ack       di
    tv[0] = '{2'd0, 4'b0000, 4'b0000, 3'd0, 5'b00000, 1'b0, 16'h0101, 16'h1234, 16'hFFFC, 8'h01, 8'h03, 5, 6, 5'b00000, 1'b0};
    tv[1] = '{2'd1, 4'b1000, 4'b1000, 3'd0, 5'b00000, 1'b0, 16'h0101, 16'h1234, 16'hFFFC, 8'h01, 8'h03, 5, 6, 5'b00000, 1'b0};
    tv[2] = '{2'd1, 4'b0010, 4'b0001, 3'd0, 5'b00000, 1'b0, 16'h0101, 16'h0103, 16'hFFFE, 8'hAA, 8'hAA, 2, 0, 5'b00000, 1'b0};
    tv[3] = '{2'd2, 4'b0000, 4'b0000, 3'd7, 5'b00000, 1'b0, 16'h0101, 16'h0038, 16'hFFFC, 8'h01, 8'h01, 3, 6, 5'b00000, 1'b0};
    tv[4] = '{2'd3, 4'b0000, 4'b0000, 3'd0, 5'b00110, 1'b0, 16'h0100, 16'h0048, 16'hFFFC, 8'h01, 8'h00, 4, 6, 5'b00010, 1'b1};
    tv[5] = '{2'd3, 4'b0000, 4'b0000, 3'd0, 5'b10000, 1'b0, 16'h0100, 16'h0060, 16'hFFFC, 8'h01, 8'h00, 4, 6, 5'b10000, 1'b1};
    tv[6] = '{2'd3, 4'b0000, 4'b0000, 3'd0, 5'b00110, 1'b1, 16'h0100, 16'h0000, 16'hFFFC, 8'h01, 8'h00, 4, 6, 5'b00000, 1'b1};
    tv[7] = '{2'd2, 4'b0000, 4'b0000, 3'd3, 5'b00000, 1'b0, 16'h0234, 16'h0018, 16'hFFFC, 8'h02, 8'h34, 3, 6, 5'b00000, 1'b0};

    repeat (6) tick();
    @(negedge clk);
    check("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tv[i], i);

    // Reset while in PUSH_HI aborts immediately.
    prep_model(16'h0101);
    issue(2'd0, 4'b0000, 3'd0);
    hit = 1'b0;
    for (cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      apply_model();
      if (read8[REG8_PCH]) hit = 1'b1;
      else tick();
    end
    check("reach_push_hi", hit, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", all_outputs(), 64'd0);
    check("mid_reset_busy", busy, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("mid_reset_stays_idle", busy, 1'b0);

    // Start held through the final PUSH_LO edge must not launch a second sequence.
    prep_model(16'h0101);
    issue(2'd2, 4'b0000, 3'd2);
    hit = 1'b0; ir = 0;
    for (cyc = 0; cyc < 100 && busy !== 1'b0 || cyc == 0; cyc++) begin
      @(negedge clk);
      if (irf) ir++;
      if (read8[REG8_PCL]) begin start = 1'b1; kind = 2'd0; hit = 1'b1; end
      if (!busy) start = 1'b0;
      apply_model();
      if (busy) tick();
    end
    start = 1'b0;
    check("busy_start_seen_push_lo", hit, 1'b1);
    check("busy_start_pc", pc, 16'h0010);
    for (int k = 0; k < 12; k++) begin
      tick();
      @(negedge clk);
      if (irf) ir++;
      if (busy) hit = 1'b0;
    end
    check("busy_start_no_relaunch", hit, 1'b1);
    check("busy_start_one_fetch", ir, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
